// File: rtl/axi4lite_master_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : axi4lite_master_bridge                                         |
// | Brief   : Local valid/ready command port to AXI4-Lite master, one        |
// |           transaction in flight. Optional response timeout is enabled    |
// |           with macro AXI4LITE_MASTER_TIMEOUT_EN.                         |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module axi4lite_master_bridge #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int STRB_W        = DATA_WIDTH / 8
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   // local command port
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_is_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [STRB_W-1:0]     req_wstrb,
   // local response port
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic                  rsp_timeout,
   // AXI4-Lite write channels
   output logic [ADDR_WIDTH-1:0] AWADDR,
   output logic [2:0]            AWPROT,
   output logic                  AWVALID,
   input  logic                  AWREADY,
   output logic [DATA_WIDTH-1:0] WDATA,
   output logic [STRB_W-1:0]     WSTRB,
   output logic                  WVALID,
   input  logic                  WREADY,
   input  logic [1:0]            BRESP,
   input  logic                  BVALID,
   output logic                  BREADY,
   // AXI4-Lite read channels
   output logic [ADDR_WIDTH-1:0] ARADDR,
   output logic [2:0]            ARPROT,
   output logic                  ARVALID,
   input  logic                  ARREADY,
   input  logic [DATA_WIDTH-1:0] RDATA,
   input  logic [1:0]            RRESP,
   input  logic                  RVALID,
   output logic                  RREADY
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR_REQ  = 3'd1,
      S_WR_RESP = 3'd2,
      S_RD_REQ  = 3'd3,
      S_RD_RESP = 3'd4,
      S_RSP     = 3'd5
   } state_t;

   localparam logic [1:0] c_resp_slverr = 2'b10;

   if ((DATA_WIDTH % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("axi4lite_master_bridge: DATA_WIDTH must be a multiple of 8 and TIMEOUT_CYCLES >= 1");
   end

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_aw_done;
   logic                  r_w_done;
   logic                  w_aw_done_nxt;
   logic                  w_w_done_nxt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [STRB_W-1:0]     r_wstrb;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic [1:0]            r_rsp_resp;
   logic                  w_accept;
   logic                  w_to_fire;
   logic                  w_stale_b;
   logic                  w_stale_r;

   // Handshake-facing controls are decoded from state so they follow it exactly.
   assign req_ready = (r_state == S_IDLE) && !w_stale_b && !w_stale_r;
   assign w_accept  = req_valid && req_ready;
   assign AWVALID   = (r_state == S_WR_REQ) && !r_aw_done;
   assign WVALID    = (r_state == S_WR_REQ) && !r_w_done;
   assign BREADY    = (r_state == S_WR_RESP) || w_stale_b;
   assign ARVALID   = (r_state == S_RD_REQ);
   assign RREADY    = (r_state == S_RD_RESP) || w_stale_r;
   assign rsp_valid = (r_state == S_RSP);

   assign AWADDR    = r_addr;
   assign ARADDR    = r_addr;
   assign AWPROT    = 3'b000;
   assign ARPROT    = 3'b000;
   assign WDATA     = r_wdata;
   assign WSTRB     = r_wstrb;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_resp  = r_rsp_resp;

   always_comb begin
      w_state_nxt   = r_state;
      w_aw_done_nxt = r_aw_done;
      w_w_done_nxt  = r_w_done;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = req_is_wr ? S_WR_REQ : S_RD_REQ;
            end
         end
         S_WR_REQ: begin
            if (AWVALID && AWREADY) w_aw_done_nxt = 1'b1;
            if (WVALID && WREADY)   w_w_done_nxt  = 1'b1;
            if (w_aw_done_nxt && w_w_done_nxt) begin
               w_aw_done_nxt = 1'b0;
               w_w_done_nxt  = 1'b0;
               w_state_nxt   = S_WR_RESP;
            end
         end
         S_WR_RESP: begin
            if (BVALID || w_to_fire) w_state_nxt = S_RSP;
         end
         S_RD_REQ: begin
            if (ARREADY) w_state_nxt = S_RD_RESP;
         end
         S_RD_RESP: begin
            if (RVALID || w_to_fire) w_state_nxt = S_RSP;
         end
         S_RSP: begin
            if (rsp_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_state     <= S_IDLE;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_rsp_rdata <= '0;
         r_rsp_resp  <= 2'b00;
      end else begin
         r_state   <= w_state_nxt;
         r_aw_done <= w_aw_done_nxt;
         r_w_done  <= w_w_done_nxt;
         if (w_accept) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
         end
         // A real B/R wins over a timeout landing in the same cycle.
         if ((r_state == S_WR_RESP) && BVALID) begin
            r_rsp_resp  <= BRESP;
            r_rsp_rdata <= '0;
         end else if ((r_state == S_RD_RESP) && RVALID) begin
            r_rsp_resp  <= RRESP;
            r_rsp_rdata <= RDATA;
         end else if (w_to_fire) begin
            r_rsp_resp  <= c_resp_slverr;
            r_rsp_rdata <= '0;
         end
      end
   end

`ifdef AXI4LITE_MASTER_TIMEOUT_EN
   localparam int                 c_cnt_w   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT_CYCLES);

   logic [c_cnt_w-1:0] r_cnt;
   logic               r_stale_b;
   logic               r_stale_r;
   logic               r_rsp_timeout;
   logic               w_counting;

   assign w_counting  = (r_state == S_WR_REQ) || (r_state == S_WR_RESP) ||
                        (r_state == S_RD_REQ) || (r_state == S_RD_RESP);
   // Only the response-wait states may time out; address VALIDs are never withdrawn.
   assign w_to_fire   = (r_cnt >= c_timeout) &&
                        (((r_state == S_WR_RESP) && !BVALID) ||
                         ((r_state == S_RD_RESP) && !RVALID));
   assign w_stale_b   = r_stale_b;
   assign w_stale_r   = r_stale_r;
   assign rsp_timeout = r_rsp_timeout;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_cnt         <= '0;
         r_stale_b     <= 1'b0;
         r_stale_r     <= 1'b0;
         r_rsp_timeout <= 1'b0;
      end else begin
         if (w_accept) begin
            r_cnt <= '0;
         end else if (w_counting && (r_cnt < c_timeout)) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_to_fire && (r_state == S_WR_RESP)) begin
            r_stale_b <= 1'b1;
         end else if (r_stale_b && BVALID) begin
            r_stale_b <= 1'b0;
         end
         if (w_to_fire && (r_state == S_RD_RESP)) begin
            r_stale_r <= 1'b1;
         end else if (r_stale_r && RVALID) begin
            r_stale_r <= 1'b0;
         end
         if (w_to_fire) begin
            r_rsp_timeout <= 1'b1;
         end else if (((r_state == S_WR_RESP) && BVALID) ||
                      ((r_state == S_RD_RESP) && RVALID)) begin
            r_rsp_timeout <= 1'b0;
         end
      end
   end
`else
   assign w_to_fire   = 1'b0;
   assign w_stale_b   = 1'b0;
   assign w_stale_r   = 1'b0;
   assign rsp_timeout = 1'b0;
`endif

endmodule
`default_nettype wire
